// File: rtl/scoreboard.sv
// In-order scoreboard: circular buffer of issued instructions that collects
// out-of-order writeback results and releases them to commit in program order.
//
// Handshakes: issue is accepted when issue_ack_o is high in a cycle
// (issue_valid_i & not full & no flush); the slot ID handed back is
// issue_trans_id_o from that same cycle. Commit pops the oldest entry on a
// cycle where commit_valid_o & commit_ack_i; commit_ack_i alone is ignored.

package scoreboard_pkg;
    localparam int NR_SB_ENTRIES = 4;
    localparam int NR_WB_PORTS   = 4;
    localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

    localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]               fu;
        logic [7:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        exception_t               ex;
    } scoreboard_entry;
endpackage

module scoreboard #(
    parameter int NR_ENTRIES    = scoreboard_pkg::NR_SB_ENTRIES,
    parameter int NR_WB_PORTS   = scoreboard_pkg::NR_WB_PORTS,
    parameter int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    output logic                                      full_o,
    input  scoreboard_pkg::scoreboard_entry           issue_instr_i,
    input  logic                                      issue_valid_i,
    output logic                                      issue_ack_o,
    output logic [TRANS_ID_BITS-1:0]                  issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]              wdata_i,
    input  scoreboard_pkg::exception_t [NR_WB_PORTS-1:0] ex_i,
    input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
    output scoreboard_pkg::scoreboard_entry           commit_instr_o,
    output logic                                      commit_valid_o,
    input  logic                                      commit_ack_i
);

    localparam int SB_TID = scoreboard_pkg::TRANS_ID_BITS;
    localparam logic [TRANS_ID_BITS-1:0] PTR_ONE   = TRANS_ID_BITS'(1);
    localparam logic [TRANS_ID_BITS:0]   CNT_ONE   = (TRANS_ID_BITS + 1)'(1);
    localparam logic [TRANS_ID_BITS:0]   CNT_FULL  = (TRANS_ID_BITS + 1)'(NR_ENTRIES);

    scoreboard_pkg::scoreboard_entry mem_q [NR_ENTRIES];
    scoreboard_pkg::scoreboard_entry mem_d [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]    occ_q, occ_d;
    logic [TRANS_ID_BITS-1:0] issue_ptr_q, issue_ptr_d;
    logic [TRANS_ID_BITS-1:0] commit_ptr_q, commit_ptr_d;
    logic [TRANS_ID_BITS:0]   count_q, count_d;

    logic ack;
    logic pop;
    scoreboard_pkg::scoreboard_entry issue_ent;

    // Output decode: everything is derived from registered state, no bypass.
    always_comb begin
        full_o           = (count_q == CNT_FULL);
        // rst_ni gating keeps the ack low while reset is held.
        ack              = issue_valid_i & ~full_o & ~flush_i & rst_ni;
        issue_ack_o      = ack;
        issue_trans_id_o = issue_ptr_q;
        commit_instr_o   = mem_q[commit_ptr_q];
        commit_valid_o   = occ_q[commit_ptr_q] & mem_q[commit_ptr_q].valid;
        pop              = commit_ack_i & commit_valid_o;
    end

    // Next-state: issue write, writebacks (highest port last so it wins), pop, flush.
    always_comb begin
        mem_d        = mem_q;
        occ_d        = occ_q;
        issue_ptr_d  = issue_ptr_q;
        commit_ptr_d = commit_ptr_q;
        count_d      = count_q;

        issue_ent          = issue_instr_i;
        issue_ent.trans_id = SB_TID'(issue_ptr_q);
        // Fetch/decode exceptions are already complete and never see a writeback.
        issue_ent.valid    = issue_instr_i.ex.valid;

        if (ack) begin
            mem_d[issue_ptr_q] = issue_ent;
            occ_d[issue_ptr_q] = 1'b1;
            issue_ptr_d        = issue_ptr_q + PTR_ONE;
        end

        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_valid_i[p] && occ_q[trans_id_i[p]] &&
                !(pop && (trans_id_i[p] == commit_ptr_q))) begin
                mem_d[trans_id_i[p]].result = wdata_i[p];
                mem_d[trans_id_i[p]].valid  = 1'b1;
                if (ex_i[p].valid) begin
                    mem_d[trans_id_i[p]].ex = ex_i[p];
                end
            end
        end

        if (pop) begin
            occ_d[commit_ptr_q]       = 1'b0;
            mem_d[commit_ptr_q].valid = 1'b0;
            commit_ptr_d              = commit_ptr_q + PTR_ONE;
        end

        if (ack && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !ack) begin
            count_d = count_q - CNT_ONE;
        end

        // Flush wins over everything else this cycle; payload fields are left stale.
        if (flush_i) begin
            occ_d        = '0;
            issue_ptr_d  = '0;
            commit_ptr_d = '0;
            count_d      = '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_d[i]       = mem_q[i];
                mem_d[i].valid = 1'b0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            occ_q        <= '0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
        end else begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= mem_d[i];
            end
            occ_q        <= occ_d;
            issue_ptr_q  <= issue_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            count_q      <= count_d;
        end
    end

endmodule
